sad_best_sel: RTL and testbench

- Downstream consumer of the SAD pipe's output stream (sad_vld / rdy_dn / sad_res / zero).
- Groups consecutive accepted SAD results into blocks of N candidates and tracks the minimum SAD and its index within each block.
- Emits one best-match record per block on its own valid/ready output.
- Sits between the SAD pipe and motion-vector decision logic.

---
 rtl/sad_best_sel.sv | 125 ++++++++++++
 tb/tb_sad_best_sel.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sad_best_sel.sv
// ============================================================================
// Module      : sad_best_sel
// Description : Groups accepted SAD results into blocks of N candidates and
//               emits the minimum SAD and its index per block on a
//               valid/ready record interface. Define SAD_BEST_ZCNT_EN to add
//               a per-block count of zero-SAD beats (best_zcnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_best_sel #(
    parameter int W = 8,
    parameter int N = 80
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sad_vld,
    output logic                     rdy_dn,
    input  logic [W+1:0]             sad_res,
    input  logic                     zero,
    output logic                     best_vld,
    input  logic                     best_rdy,
    output logic [W+1:0]             best_sad,
`ifdef SAD_BEST_ZCNT_EN
    output logic [$clog2(N):0]       best_zcnt,
`endif
    output logic [$clog2(N)-1:0]     best_idx
);

    localparam int IDXW = $clog2(N);
    localparam int ZCW  = IDXW + 1;

    localparam logic [IDXW-1:0] c_last = IDXW'(N - 1);
    localparam logic [IDXW-1:0] c_one  = IDXW'(1);

    logic [IDXW-1:0] r_cnt;
    logic [W+1:0]    r_cur_min;
    logic [IDXW-1:0] r_cur_idx;
    logic            r_best_vld;
    logic [W+1:0]    r_best_sad;
    logic [IDXW-1:0] r_best_idx;

    logic            w_last;
    logic            w_rdy;
    logic            w_acc;
    logic [W+1:0]    w_new_min;
    logic [IDXW-1:0] w_new_idx;

    assign w_last = (r_cnt == c_last);
    // Only the closing beat has to wait for the output register to free up.
    assign w_rdy  = !w_last || !r_best_vld || best_rdy;
    assign w_acc  = sad_vld && w_rdy;

    // Running minimum including the current beat; strict compare keeps the earlier index on ties.
    always_comb begin
        w_new_min = r_cur_min;
        w_new_idx = r_cur_idx;
        if (r_cnt == '0) begin
            w_new_min = sad_res;
            w_new_idx = '0;
        end else if (sad_res < r_cur_min) begin
            w_new_min = sad_res;
            w_new_idx = r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_cur_min  <= '0;
            r_cur_idx  <= '0;
            r_best_vld <= 1'b0;
            r_best_sad <= '0;
            r_best_idx <= '0;
        end else begin
            if (w_acc) begin
                r_cur_min <= w_new_min;
                r_cur_idx <= w_new_idx;
                r_cnt     <= w_last ? '0 : r_cnt + c_one;
            end
            if (w_acc && w_last) begin
                r_best_vld <= 1'b1;
                r_best_sad <= w_new_min;
                r_best_idx <= w_new_idx;
            end else if (r_best_vld && best_rdy) begin
                r_best_vld <= 1'b0;
            end
        end
    end

`ifdef SAD_BEST_ZCNT_EN
    logic [ZCW-1:0] r_zcnt;
    logic [ZCW-1:0] r_best_zcnt;
    logic [ZCW-1:0] w_zcnt_nxt;

    assign w_zcnt_nxt = ((r_cnt == '0) ? '0 : r_zcnt) + ZCW'(zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zcnt      <= '0;
            r_best_zcnt <= '0;
        end else begin
            if (w_acc) begin
                r_zcnt <= w_zcnt_nxt;
            end
            if (w_acc && w_last) begin
                r_best_zcnt <= w_zcnt_nxt;
            end
        end
    end

    assign best_zcnt = r_best_zcnt;
`else
    logic [ZCW-1:0] w_unused_zero;
    assign w_unused_zero = ZCW'(zero);
`endif

    assign rdy_dn   = w_rdy;
    assign best_vld = r_best_vld;
    assign best_sad = r_best_sad;
    assign best_idx = r_best_idx;

endmodule

`default_nettype wire

// File: tb/tb_sad_best_sel.sv
// ============================================================================
// Module      : tb_sad_best_sel
// Description : Directed self-checking bench for sad_best_sel with W=8, N=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sad_best_sel;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int IDXW = $clog2(N);

    logic            clk;
    logic            rst;
    logic            sad_vld;
    logic            rdy_dn;
    logic [W+1:0]    sad_res;
    logic            zero;
    logic            best_vld;
    logic            best_rdy;
    logic [W+1:0]    best_sad;
    logic [IDXW-1:0] best_idx;
`ifdef SAD_BEST_ZCNT_EN
    logic [IDXW:0]   best_zcnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    sad_best_sel #(.W(W), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .sad_vld  (sad_vld),
        .rdy_dn   (rdy_dn),
        .sad_res  (sad_res),
        .zero     (zero),
        .best_vld (best_vld),
        .best_rdy (best_rdy),
        .best_sad (best_sad),
`ifdef SAD_BEST_ZCNT_EN
        .best_zcnt(best_zcnt),
`endif
        .best_idx (best_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic drive(input logic v, input int sad, input logic z);
        @(negedge clk);
        sad_vld = v;
        sad_res = sad[W+1:0];
        zero    = z;
        #1;
    endtask

    task automatic chk_rec(input string tag, input logic v, input int sad, input int idx);
        chk({tag, "_vld"}, 32'(best_vld), 32'(v));
        chk({tag, "_sad"}, 32'(best_sad), 32'(sad));
        chk({tag, "_idx"}, 32'(best_idx), 32'(idx));
    endtask

    initial begin
        int acc;
        int cyc;
        logic v;

        rst      = 1'b1;
        sad_vld  = 1'b0;
        sad_res  = '0;
        zero     = 1'b0;
        best_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk_rec("reset", 1'b0, 0, 0);
        chk("reset_rdy", 32'(rdy_dn), 1);
        rst = 1'b0;

        // Block 9,3,7,5: single-cycle record one cycle after the 4th accept.
        drive(1, 9, 0);
        drive(1, 3, 0);
        drive(1, 7, 0);
        drive(1, 5, 0);
        chk("b1_novld_before_last", 32'(best_vld), 0);
        drive(0, 0, 0);
        chk_rec("b1", 1'b1, 3, 1);
        drive(0, 0, 0);
        chk("b1_pulse_end", 32'(best_vld), 0);

        // Back-to-back blocks 6,2,2,8 then 0,0,0,0 with no bubble between.
        drive(1, 6, 0);
        drive(1, 2, 0);
        drive(1, 2, 0);
        drive(1, 8, 0);
        drive(1, 0, 0);
        chk_rec("b2_tie", 1'b1, 2, 1);
        chk("b2_rdy_b2b", 32'(rdy_dn), 1);
        drive(1, 0, 0);
        chk("b2_vld_clear", 32'(best_vld), 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        chk_rec("b3_zero", 1'b1, 0, 0);

        // Backpressure: block A 4,1,4,4 is held while block B 5,7,2,3 stalls on its last beat.
        drive(1, 4, 0);
        drive(1, 1, 0);
        drive(1, 4, 0);
        drive(1, 4, 0);
        drive(1, 5, 0);
        best_rdy = 1'b0;
        #1;
        chk_rec("bpA_rec", 1'b1, 1, 1);
        drive(1, 7, 0);
        drive(1, 2, 0);
        drive(1, 3, 0);
        chk("bp_rdy_low", 32'(rdy_dn), 0);
        chk_rec("bpA_hold1", 1'b1, 1, 1);
        drive(1, 3, 0);
        chk("bp_rdy_low2", 32'(rdy_dn), 0);
        chk_rec("bpA_hold2", 1'b1, 1, 1);
        best_rdy = 1'b1;
        #1;
        chk("bp_rdy_release", 32'(rdy_dn), 1);
        drive(0, 0, 0);
        chk_rec("bpB_rec", 1'b1, 2, 2);
        drive(0, 0, 0);
        chk("bpB_drained", 32'(best_vld), 0);

        // Full-scale SAD, then the same value under a random valid duty.
        drive(1, 1023, 0);
        drive(1, 1023, 0);
        drive(1, 1023, 0);
        drive(1, 1023, 0);
        drive(0, 0, 0);
        chk_rec("max", 1'b1, 1023, 0);
        acc = 0;
        cyc = 0;
        while (acc < N && cyc < 200) begin
            v = ($urandom_range(0, 3) != 0);
            drive(v, 1023, 0);
            if (v && rdy_dn) acc++;
            cyc++;
            if (acc < N && best_vld) chk("rand_early_vld", 32'(best_vld), 0);
        end
        chk("rand_accepts", 32'(acc), N);
        drive(0, 0, 0);
        chk_rec("rand_max", 1'b1, 1023, 0);

        // Reset after two accepted beats discards the partial block.
        drive(1, 1, 0);
        drive(1, 1, 0);
        drive(0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_rdy", 32'(rdy_dn), 1);
        @(negedge clk);
        #1;
        chk("rst_mid_vld", 32'(best_vld), 0);
        chk("rst_mid_rdy2", 32'(rdy_dn), 1);
        rst = 1'b0;
        drive(1, 8, 0);
        drive(1, 6, 0);
        drive(1, 9, 0);
        chk("rst_no_stale_rec", 32'(best_vld), 0);
        drive(1, 7, 0);
        chk("rst_no_stale_rec2", 32'(best_vld), 0);
        drive(0, 0, 0);
        chk_rec("rst_new", 1'b1, 6, 1);

`ifdef SAD_BEST_ZCNT_EN
        drive(1, 0, 1);
        drive(1, 5, 0);
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(0, 0, 0);
        chk_rec("zc", 1'b1, 0, 0);
        chk("zc_cnt", 32'(best_zcnt), 3);
`endif

        drive(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
